// File: rtl/fir_filter.sv
// 71-tap direct-form FIR with a run-time writable coefficient array and a 12-bit saturating output.
// Latency: x_n is captured into the delay line at edge N; its first product term appears on y_n at edge N+1.
// No backpressure: one sample in and one sample out every cycle; coefficient writes happen alongside filtering.
module fir_filter #(
    parameter int NTAPS = 71
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  x_n,
    input  logic        write_en,
    input  logic [7:0]  coefficient,
    input  logic [6:0]  addr,
    output logic [11:0] y_n
);

    logic signed [7:0]  c [NTAPS];
    logic signed [3:0]  d [NTAPS];
    logic signed [19:0] acc;
    logic [11:0]        y_sat;

    // Sample delay line: shifts every cycle, newest sample at d[0].
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NTAPS; k++) d[k] <= '0;
        end else begin
            d[0] <= x_n;
            for (int k = 1; k < NTAPS; k++) d[k] <= d[k-1];
        end
    end

    // Coefficient registers: addresses at or beyond NTAPS match no register, so those writes are dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NTAPS; k++) c[k] <= '0;
        end else if (write_en) begin
            for (int k = 0; k < NTAPS; k++) begin
                if (addr == 7'(k)) c[k] <= coefficient;
            end
        end
    end

    // Sum of products. Operands are sign-extended to the accumulator width, so the low 20 bits
    // of each product are the exact signed product and the 71-term sum cannot wrap.
    always_comb begin
        acc = '0;
        for (int k = 0; k < NTAPS; k++) begin
            acc = acc + ({{12{c[k][7]}}, c[k]} * {{16{d[k][3]}}, d[k]});
        end
    end

    // Clamp the full-precision sum to the 12-bit signed output range.
    always_comb begin
        if (acc > 20'sd2047)
            y_sat = 12'h7FF;
        else if (acc < -20'sd2048)
            y_sat = 12'h800;
        else
            y_sat = acc[11:0];
    end

    // Output register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) y_n <= '0;
        else      y_n <= y_sat;
    end

endmodule

// File: tb/tb_fir_filter.sv
// Self-checking bench for fir_filter: directed impulse/step/boundary/reset scenarios plus random traffic.
// Inputs change on the falling edge; y_n is sampled 1 time unit after each rising edge.
// The reference model keeps the last 71 samples and the coefficient values as plain integers.
module tb_fir_filter;

    localparam int NTAPS = 71;

    logic        clk;
    logic        rst;
    logic [3:0]  x_n;
    logic        write_en;
    logic [7:0]  coefficient;
    logic [6:0]  addr;
    logic [11:0] y_n;

    int checks = 0;
    int errors = 0;

    int mc [NTAPS];
    int mx [$];

    fir_filter #(.NTAPS(NTAPS)) dut (
        .clk        (clk),
        .rst        (rst),
        .x_n        (x_n),
        .write_en   (write_en),
        .coefficient(coefficient),
        .addr       (addr),
        .y_n        (y_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int sat12(input int v);
        if (v > 2047) return 2047;
        if (v < -2048) return -2048;
        return v;
    endfunction

    function automatic int model_dot();
        int s = 0;
        for (int k = 0; k < NTAPS; k++) s += mc[k] * mx[k];
        return s;
    endfunction

    task automatic model_clear();
        mx.delete();
        for (int k = 0; k < NTAPS; k++) begin
            mc[k] = 0;
            mx.push_back(0);
        end
    endtask

    // One clock cycle: drive on the falling edge, predict from the state before the rising edge,
    // then advance the model and return 1 time unit after the edge.
    task automatic cyc(input int x, input bit we, input int a, input int cf, output int e);
        @(negedge clk);
        x_n = 4'(x);
        write_en = we;
        addr = 7'(a);
        coefficient = 8'(cf);
        @(posedge clk);
        e = sat12(model_dot());
        mx.push_front(x);
        void'(mx.pop_back());
        if (we && a < NTAPS) mc[a] = cf;
        #1;
    endtask

    task automatic load_ramp();
        int e;
        for (int i = 0; i < NTAPS; i++) cyc(0, 1'b1, i, i, e);
    endtask

    task automatic flush();
        int e;
        for (int i = 0; i < NTAPS + 2; i++) cyc(0, 1'b0, 0, 0, e);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        x_n = '0;
        write_en = 1'b0;
        addr = '0;
        coefficient = '0;
        model_clear();
        #1;
        checks++;
        if (y_n !== 12'd0) begin
            errors++;
            $display("FAIL reset_initial: y_n=%0d expected 0", $signed(y_n));
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
    endtask

    // Impulse of height amp through the ramp coefficients; c70 is the expected tap-70 coefficient.
    task automatic run_impulse(input string name, input int amp, input int c70);
        int e, exp_v;
        cyc(amp, 1'b0, 0, 0, e);
        checks++;
        if (y_n !== 12'd0) begin
            errors++;
            $display("FAIL %s_edgeN: y_n=%0d expected 0", name, $signed(y_n));
        end
        for (int k = 0; k <= NTAPS; k++) begin
            cyc(0, 1'b0, 0, 0, e);
            if (k == NTAPS) exp_v = 0;
            else if (k == NTAPS - 1) exp_v = sat12(amp * c70);
            else exp_v = sat12(amp * k);
            checks++;
            if (y_n !== 12'(exp_v)) begin
                errors++;
                $display("FAIL %s_k%0d: y_n=%0d expected %0d", name, k, $signed(y_n), exp_v);
            end
        end
    endtask

    task automatic test_impulse();
        load_ramp();
        run_impulse("impulse", 1, 70);
    endtask

    task automatic test_neg_impulse();
        run_impulse("neg_impulse", -1, 70);
    endtask

    task automatic run_step(input string name, input int amp);
        int e, exp_v;
        cyc(amp, 1'b0, 0, 0, e);
        for (int k = 0; k <= 80; k++) begin
            cyc(amp, 1'b0, 0, 0, e);
            exp_v = sat12(amp * k * (k + 1) / 2);
            checks++;
            if (y_n !== 12'(exp_v)) begin
                errors++;
                $display("FAIL %s_k%0d: y_n=%0d expected %0d", name, k, $signed(y_n), exp_v);
            end
        end
    endtask

    task automatic test_step();
        run_step("step", 1);
        flush();
    endtask

    task automatic test_neg_step();
        run_step("neg_step", -1);
        flush();
    endtask

    task automatic test_addr_boundary();
        int e;
        cyc(0, 1'b1, 71, 5, e);
        cyc(0, 1'b1, 127, 5, e);
        run_impulse("addr_oob", 1, 70);
        cyc(0, 1'b1, 70, -128, e);
        run_impulse("addr_last", 7, -128);
    endtask

    task automatic test_reset_mid();
        int e;
        run_step("pre_reset", 1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (y_n !== 12'd0) begin
            errors++;
            $display("FAIL reset_async: y_n=%0d expected 0", $signed(y_n));
        end
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (y_n !== 12'd0) begin
            errors++;
            $display("FAIL reset_held: y_n=%0d expected 0", $signed(y_n));
        end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < NTAPS + 10; i++) begin
            cyc(7, 1'b0, 0, 0, e);
            checks++;
            if (y_n !== 12'd0) begin
                errors++;
                $display("FAIL reset_coef_clear_%0d: y_n=%0d expected 0", i, $signed(y_n));
            end
        end
    endtask

    task automatic test_random();
        int e, x, a, cf;
        bit we;
        for (int i = 0; i < 600; i++) begin
            x  = int'($urandom_range(0, 15)) - 8;
            we = ($urandom_range(0, 3) == 0);
            a  = int'($urandom_range(0, 127));
            cf = int'($urandom_range(0, 255)) - 128;
            cyc(x, we, a, cf, e);
            checks++;
            if (y_n !== 12'(e)) begin
                errors++;
                $display("FAIL random_%0d: y_n=%0d expected %0d", i, $signed(y_n), e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_neg_impulse();
        test_step();
        test_neg_step();
        test_addr_boundary();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
